// File: rtl/fetch_responder_if.sv
// ============================================================================
// Module : fetch_responder_if
// Brief  : Fetch-stage and instruction-bus signal bundle for fetch_responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface fetch_responder_if;
  logic        fetchEnable;
  logic [31:0] fetchAddress;
  logic        fetchBusy;
  logic [31:0] fetchData;
  logic        fetchError;
  logic        flush;
  logic [31:0] memAddress;
  logic        memRequest;
  logic        memAck;
  logic        memError;
  logic [31:0] memDataRead;

  // Responder side: serves the fetch stage and masters the memory bus.
  modport slave (
    input  fetchEnable, fetchAddress, flush, memAck, memError, memDataRead,
    output fetchBusy, fetchData, fetchError, memAddress, memRequest
  );

  modport master (
    output fetchEnable, fetchAddress, flush, memAck, memError, memDataRead,
    input  fetchBusy, fetchData, fetchError, memAddress, memRequest
  );
endinterface

`default_nettype wire

// File: rtl/fetch_responder.sv
// ============================================================================
// Module : fetch_responder
// Brief  : Single-entry instruction line buffer with bus fill and timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_responder #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd64
) (
  input  logic             clk,
  input  logic             rst,
  fetch_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [7:0]  TO_LAST  = TIMEOUT_CYCLES - 8'd1;
  localparam logic [31:0] NO_INSTR = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [29:0] tag_q,   tag_d;
  logic [31:0] data_q,  data_d;
  logic [29:0] lat_q,   lat_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic        pend_q,  pend_d;

  logic hit;
  logic timeout;
  logic addr_lsb_unused;

  assign addr_lsb_unused = ^bus.fetchAddress[1:0];

  // Flush suppresses the hit in the same cycle it invalidates the buffer.
  assign hit = (state_q == IDLE) && valid_q && !bus.flush &&
               (tag_q == bus.fetchAddress[31:2]);
  assign timeout = (TIMEOUT_CYCLES != 8'd0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      tag_q   <= 30'd0;
      data_q  <= NO_INSTR;
      lat_q   <= 30'd0;
      cnt_q   <= 8'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;

    bus.memRequest = 1'b0;
    bus.memAddress = {lat_q, 2'b00};
    bus.fetchError = 1'b0;
    bus.fetchBusy  = 1'b0;
    bus.fetchData  = valid_q ? data_q : NO_INSTR;

    unique case (state_q)
      IDLE: begin
        bus.fetchBusy = bus.fetchEnable && !hit;
        if (bus.flush) begin
          valid_d = 1'b0;
        end
        if (bus.fetchEnable && !hit) begin
          lat_d   = bus.fetchAddress[31:2];
          cnt_d   = 8'd0;
          pend_d  = 1'b0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        bus.memRequest = 1'b1;
        bus.fetchBusy  = bus.fetchEnable;
        cnt_d          = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
        if (bus.flush) begin
          pend_d = 1'b1;
        end
        // Error has priority over a coincident acknowledge.
        if (bus.memError || timeout) begin
          valid_d = 1'b0;
          pend_d  = 1'b0;
          state_d = ERROR;
        end else if (bus.memAck) begin
          data_d  = bus.memDataRead;
          tag_d   = lat_q;
          valid_d = !(pend_q || bus.flush);
          pend_d  = 1'b0;
          state_d = IDLE;
        end
      end

      ERROR: begin
        bus.fetchError = 1'b1;
        bus.fetchData  = NO_INSTR;
        state_d        = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_responder.sv
// ============================================================================
// Module : tb_fetch_responder
// Brief  : Directed vector bench for fetch_responder (TIMEOUT_CYCLES = 4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_responder;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  fetch_responder_if bus ();

  fetch_responder #(.TIMEOUT_CYCLES(8'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic        fl;
    logic        ack;
    logic        err;
    logic [31:0] rd;
    logic        busy;
    logic [31:0] data;
    logic        ferr;
    logic        req;
    logic [31:0] maddr;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic en, logic [31:0] addr, logic fl, logic ack,
                              logic err, logic [31:0] rd, logic busy,
                              logic [31:0] data, logic ferr, logic req,
                              logic [31:0] maddr);
    vec_t v;
    v.en = en; v.addr = addr; v.fl = fl; v.ack = ack; v.err = err; v.rd = rd;
    v.busy = busy; v.data = data; v.ferr = ferr; v.req = req; v.maddr = maddr;
    vq.push_back(v);
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(logic en, logic [31:0] addr, logic fl, logic ack,
                       logic err, logic [31:0] rd);
    bus.fetchEnable  = en;
    bus.fetchAddress = addr;
    bus.flush        = fl;
    bus.memAck       = ack;
    bus.memError     = err;
    bus.memDataRead  = rd;
  endtask

  localparam logic [31:0] FF = 32'hFFFF_FFFF;

  initial begin
    int req_cycles;
    bit saw_err;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 0, {31'd0, bus.fetchBusy}, 32'd0);
    check("rst_data", 0, bus.fetchData, FF);
    check("rst_ferr", 0, {31'd0, bus.fetchError}, 32'd0);
    check("rst_req",  0, {31'd0, bus.memRequest}, 32'd0);
    rst = 1'b1;

    //   en  addr          fl ack err rd            busy data          ferr req maddr
    add(1, 32'h100, 0, 0, 0, 32'h0,        1, FF,           0, 0, 32'h0);   // cold miss
    add(1, 32'h100, 0, 0, 0, 32'h0,        1, FF,           0, 1, 32'h100);
    add(1, 32'h100, 0, 0, 0, 32'h0,        1, FF,           0, 1, 32'h100);
    add(1, 32'h100, 0, 1, 0, 32'h13,       1, FF,           0, 1, 32'h100);
    add(1, 32'h100, 0, 0, 0, 32'h0,        0, 32'h13,       0, 0, 32'h0);   // hit
    add(1, 32'h102, 0, 0, 0, 32'h0,        0, 32'h13,       0, 0, 32'h0);   // alias
    add(0, 32'h102, 0, 0, 0, 32'h0,        0, 32'h13,       0, 0, 32'h0);
    add(1, 32'h100, 1, 0, 0, 32'h0,        1, 32'h13,       0, 0, 32'h0);   // idle flush
    add(1, 32'h100, 1, 0, 0, 32'h0,        1, FF,           0, 1, 32'h100); // wait flush
    add(1, 32'h100, 0, 1, 0, 32'h55,       1, FF,           0, 1, 32'h100);
    add(1, 32'h100, 0, 0, 0, 32'h0,        1, FF,           0, 0, 32'h0);   // miss again
    add(1, 32'h100, 0, 0, 0, 32'h0,        1, FF,           0, 1, 32'h100);
    add(1, 32'h100, 0, 1, 0, 32'h77,       1, FF,           0, 1, 32'h100);
    add(1, 32'h100, 0, 0, 0, 32'h0,        0, 32'h77,       0, 0, 32'h0);
    add(1, 32'h200, 0, 0, 0, 32'h0,        1, 32'h77,       0, 0, 32'h0);   // addr change
    add(1, 32'h204, 0, 0, 0, 32'h0,        1, 32'h77,       0, 1, 32'h200);
    add(1, 32'h204, 0, 1, 0, 32'hAAAA,     1, 32'h77,       0, 1, 32'h200);
    add(1, 32'h204, 0, 0, 0, 32'h0,        1, 32'hAAAA,     0, 0, 32'h0);
    add(1, 32'h204, 0, 0, 0, 32'h0,        1, 32'hAAAA,     0, 1, 32'h204);
    add(1, 32'h204, 0, 1, 0, 32'hBBBB,     1, 32'hAAAA,     0, 1, 32'h204);
    add(1, 32'h204, 0, 0, 0, 32'h0,        0, 32'hBBBB,     0, 0, 32'h0);
    add(1, 32'h200, 0, 0, 0, 32'h0,        1, 32'hBBBB,     0, 0, 32'h0);   // bus error
    add(1, 32'h200, 0, 0, 1, 32'h0,        1, 32'hBBBB,     0, 1, 32'h200);
    add(1, 32'h200, 0, 0, 0, 32'h0,        0, FF,           1, 0, 32'h0);
    add(1, 32'h200, 0, 0, 0, 32'h0,        1, FF,           0, 0, 32'h0);
    add(1, 32'h200, 0, 1, 1, 32'h1234,     1, FF,           0, 1, 32'h200); // ack+err
    add(1, 32'h200, 0, 0, 0, 32'h0,        0, FF,           1, 0, 32'h0);
    add(0, 32'h200, 0, 0, 0, 32'h0,        0, FF,           0, 0, 32'h0);
    add(1, 32'h300, 0, 0, 0, 32'h0,        1, FF,           0, 0, 32'h0);   // enable drop
    add(0, 32'h300, 0, 0, 0, 32'h0,        0, FF,           0, 1, 32'h300);
    add(0, 32'h300, 0, 1, 0, 32'h3,        0, FF,           0, 1, 32'h300);
    add(1, 32'h300, 0, 0, 0, 32'h0,        0, 32'h3,        0, 0, 32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive(vq[i].en, vq[i].addr, vq[i].fl, vq[i].ack, vq[i].err, vq[i].rd);
      @(negedge clk);
      check("busy", i, {31'd0, bus.fetchBusy}, {31'd0, vq[i].busy});
      check("data", i, bus.fetchData, vq[i].data);
      check("ferr", i, {31'd0, bus.fetchError}, {31'd0, vq[i].ferr});
      check("req",  i, {31'd0, bus.memRequest}, {31'd0, vq[i].req});
      if (vq[i].req) check("maddr", i, bus.memAddress, vq[i].maddr);
    end

    // Timeout: no acknowledge ever arrives.
    @(posedge clk); #1;
    drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("to_miss", 0, {31'd0, bus.fetchBusy}, 32'd1);
    req_cycles = 0;
    saw_err    = 1'b0;
    for (int c = 0; c < 16 && !saw_err; c++) begin
      @(negedge clk);
      if (bus.memRequest) req_cycles++;
      if (bus.fetchError) begin
        saw_err = 1'b1;
        check("to_busy", c, {31'd0, bus.fetchBusy}, 32'd0);
        check("to_data", c, bus.fetchData, FF);
        check("to_req",  c, {31'd0, bus.memRequest}, 32'd0);
      end
    end
    check("to_seen",   0, {31'd0, saw_err}, 32'd1);
    check("to_cycles", 0, req_cycles, 32'd4);
    @(negedge clk);
    check("to_pulse", 0, {31'd0, bus.fetchError}, 32'd0);

    // Asynchronous reset in the middle of a fill.
    @(posedge clk); #1;
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'h33);
    @(negedge clk);
    check("ar_wait", 0, {31'd0, bus.memRequest}, 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ar_req_pre", 0, {31'd0, bus.memRequest}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("ar_req",  0, {31'd0, bus.memRequest}, 32'd0);
    check("ar_data", 0, bus.fetchData, FF);
    drive(1'b0, 32'h500, 1'b0, 1'b1, 1'b0, 32'h99);
    #1;
    check("ar_busy", 0, {31'd0, bus.fetchBusy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("ar_nohit", 0, {31'd0, bus.fetchBusy}, 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("ar_restart", 0, {31'd0, bus.memRequest}, 32'd1);
    check("ar_raddr",   0, bus.memAddress, 32'h300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
